// File: rtl/keyvalue_pkg.sv
// Shared types and constants for the keyvalue initiator and its neighbours.
// Optional statistics are enabled with KEYVALUE_INITIATOR_STATS_EN.
package keyvalue_pkg;

  localparam int         KV_DW         = 8;
  localparam int         KV_SLOTS      = 12;
  localparam logic [3:0] KV_SEL_ALL    = 4'hF;
  localparam int         KV_INSERT_ADR = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RSP   = 2'd2,
    ABORT = 2'd3
  } kvi_state_t;

endpackage

// File: rtl/keyvalue_initiator_if.sv
// Command/response stream plus keyvalue slave bus. The master modport is the
// initiator side; the slave modport is the host-and-store environment side.
interface keyvalue_initiator_if
  import keyvalue_pkg::*;
#(
  parameter int DW = KV_DW
);

  // valid/ready: a transfer happens on a clock edge where both are high;
  // valid holds its payload stable until then, ready may toggle freely.
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [DW-1:0] cmd_adr;
  logic [DW-1:0] cmd_key;
  logic [DW-1:0] cmd_dat;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_timeout;

  logic [DW-1:0] KEY_o;
  logic [DW-1:0] ADR_o;
  logic [DW-1:0] DAT_o;
  logic          WE_o;
  logic          STB_o;
  logic          CYC_o;
  logic [3:0]    SEL_o;
  logic          RESET_o;
  logic          ACK_i;
  logic          STALL_i;
  logic [DW-1:0] DAT_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_key, cmd_dat, rsp_ready,
    input  ACK_i, STALL_i, DAT_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_timeout,
    output KEY_o, ADR_o, DAT_o, WE_o, STB_o, CYC_o, SEL_o, RESET_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_key, cmd_dat, rsp_ready,
    output ACK_i, STALL_i, DAT_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_timeout,
    input  KEY_o, ADR_o, DAT_o, WE_o, STB_o, CYC_o, SEL_o, RESET_o
  );

endinterface

// File: rtl/keyvalue_timeout_ctr.sv
// Clearable up-counter that parks at TIMEOUT-1 and flags the terminal count,
// so it can never wrap while a request is outstanding.
module keyvalue_timeout_ctr #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_o = (count_q == TC_VAL);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/keyvalue_initiator.sv
// Single-beat bus initiator for the keyvalue store with lookup-miss timeout.
// Define KEYVALUE_INITIATOR_STATS_EN to add the stat_ops/stat_timeouts counters.
module keyvalue_initiator
  import keyvalue_pkg::*;
#(
  parameter int DW      = KV_DW,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  keyvalue_initiator_if.master bus,
`ifdef KEYVALUE_INITIATOR_STATS_EN
  output logic [CNT_W-1:0]     stat_ops,
  output logic [CNT_W-1:0]     stat_timeouts,
`endif
  output kvi_state_t           dbg_state_o
);

  kvi_state_t    state_q, state_d;
  logic [DW-1:0] key_q, adr_q, dat_q;
  logic          we_q;
  logic [DW-1:0] rsp_dat_q;
  logic          rsp_to_q;
  logic          cmd_ready_w;
  logic          accept;
  logic          tc;
  logic          ack_in_req;
  logic          timeout_hit;

  assign accept      = bus.cmd_valid && cmd_ready_w;
  assign ack_in_req  = (state_q == REQ) && bus.ACK_i;
  assign timeout_hit = (state_q == REQ) && !bus.ACK_i && tc;

  keyvalue_timeout_ctr #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .clear_i  (accept),
    .enable_i ((state_q == REQ) && !bus.ACK_i),
    .tc_o     (tc)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ACK wins over a timeout that lands in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ: begin
        if (bus.ACK_i)  state_d = RSP;
        else if (tc)    state_d = ABORT;
      end
      ABORT:   state_d = RSP;
      RSP:     if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A slave still driving ACK ignores STB, so launching is held off then.
  always_comb begin
    cmd_ready_w = (state_q == IDLE) && !bus.ACK_i && !bus.STALL_i;
    bus.cmd_ready = cmd_ready_w;
    bus.STB_o     = (state_q == REQ);
    bus.CYC_o     = (state_q == REQ);
    bus.RESET_o   = (state_q == ABORT);
    bus.rsp_valid = (state_q == RSP);
    bus.SEL_o     = KV_SEL_ALL;
    bus.KEY_o     = key_q;
    bus.ADR_o     = adr_q;
    bus.DAT_o     = dat_q;
    bus.WE_o      = we_q;
    bus.rsp_dat     = rsp_dat_q;
    bus.rsp_timeout = rsp_to_q;
    dbg_state_o   = state_q;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      key_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      rsp_dat_q <= '0;
      rsp_to_q  <= 1'b0;
    end else begin
      if (accept) begin
        key_q <= bus.cmd_key;
        adr_q <= bus.cmd_adr;
        dat_q <= bus.cmd_dat;
        we_q  <= bus.cmd_we;
      end
      if (ack_in_req) begin
        rsp_dat_q <= bus.DAT_i;
        rsp_to_q  <= 1'b0;
      end else if (state_q == ABORT) begin
        rsp_dat_q <= '0;
        rsp_to_q  <= 1'b1;
      end
    end
  end

`ifdef KEYVALUE_INITIATOR_STATS_EN
  logic [CNT_W-1:0] ops_q, tmo_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ops_q <= '0;
      tmo_q <= '0;
    end else begin
      if (ack_in_req && (ops_q != '1))  ops_q <= ops_q + 1'b1;
      if (timeout_hit && (tmo_q != '1)) tmo_q <= tmo_q + 1'b1;
    end
  end

  assign stat_ops      = ops_q;
  assign stat_timeouts = tmo_q;
`else
  logic unused_stats;
  assign unused_stats = timeout_hit;
`endif

endmodule

// File: tb/tb_keyvalue_initiator.sv
// Directed bench for keyvalue_initiator against a small behavioural keyvalue store.
// Build with KEYVALUE_INITIATOR_STATS_EN to also check the statistics counters.
module tb_keyvalue_initiator;
  import keyvalue_pkg::*;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_CNT_W   = 16;

  typedef struct {
    logic       we;
    logic [7:0] adr;
    logic [7:0] key;
    logic [7:0] dat;
    int         hold;
    logic [7:0] exp_dat;
    logic       exp_to;
    int         exp_lat;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  keyvalue_initiator_if #(.DW(8)) bus ();
  kvi_state_t dbg_state;
`ifdef KEYVALUE_INITIATOR_STATS_EN
  logic [TB_CNT_W-1:0] stat_ops, stat_timeouts;
`endif

  keyvalue_initiator #(
    .DW      (8),
    .TIMEOUT (TB_TIMEOUT),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .bus           (bus),
`ifdef KEYVALUE_INITIATOR_STATS_EN
    .stat_ops      (stat_ops),
    .stat_timeouts (stat_timeouts),
`endif
    .dbg_state_o   (dbg_state)
  );

  // ---------------- behavioural store ----------------
  logic       slave_ack = 1'b0;
  logic       force_ack = 1'b0;
  logic [7:0] key_mem [KV_SLOTS];
  logic [7:0] dat_mem [KV_SLOTS];
  logic       vld_mem [KV_SLOTS];
  int         next_free;
  int         wait_q;
  logic       stb_prev;

  assign bus.ACK_i = slave_ack | force_ack;

  task automatic slave_op();
    int slot;
    bus.DAT_i = 8'hBD;
    if (bus.WE_o) begin
      if (bus.ADR_o == 8'(KV_INSERT_ADR)) begin
        slot = next_free;
        next_free++;
      end else begin
        slot = int'(bus.ADR_o);
      end
      key_mem[slot] = bus.KEY_o;
      dat_mem[slot] = bus.DAT_o;
      vld_mem[slot] = 1'b1;
      bus.DAT_i = 8'(slot);
      slave_ack = 1'b1;
    end else if (bus.ADR_o == 8'(KV_INSERT_ADR)) begin
      for (int s = 1; s < KV_SLOTS; s++) begin
        if (vld_mem[s] && key_mem[s] == bus.KEY_o) begin
          bus.DAT_i = dat_mem[s];
          slave_ack = 1'b1;
        end
      end
    end else begin
      bus.DAT_i = dat_mem[bus.ADR_o];
      slave_ack = 1'b1;
    end
  endtask

  // ACK is a one-cycle pulse two cycles after STB rises; a miss never ACKs.
  initial begin
    for (int s = 0; s < KV_SLOTS; s++) begin
      key_mem[s] = '0;
      dat_mem[s] = '0;
      vld_mem[s] = 1'b0;
    end
    next_free = 0;
    wait_q    = 0;
    stb_prev  = 1'b0;
    bus.DAT_i = '0;
    forever begin
      @(negedge sys_clk);
      slave_ack = 1'b0;
      if (!bus.STB_o) begin
        wait_q = 0;
      end else if (!stb_prev) begin
        wait_q = 2;
      end else if (wait_q > 0) begin
        wait_q--;
        if (wait_q == 0) slave_op();
      end
      stb_prev = bus.STB_o;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cmd(input int idx, input vec_t v);
    int         n, lat, pulses;
    logic       launch_ok, hold_ok, bp_ok, rel_ok;
    logic [8:0] exp;
    logic [7:0] got_dat;
    logic       got_to;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check($sformatf("v%0d_ready", idx), 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = v.we;
    bus.cmd_adr   = v.adr;
    bus.cmd_key   = v.key;
    bus.cmd_dat   = v.dat;
    exp_q.push_back({v.exp_to, v.exp_dat});
    @(posedge sys_clk);
    @(negedge sys_clk);
    launch_ok = bus.STB_o && bus.CYC_o && bus.WE_o == v.we && bus.ADR_o == v.adr &&
                bus.KEY_o == v.key && bus.DAT_o == v.dat && bus.SEL_o == 4'hF;
    // Keep a junk command on the inputs; it must neither launch nor disturb the bus.
    bus.cmd_we  = 1'($urandom_range(0, 1));
    bus.cmd_adr = 8'($urandom_range(0, 255));
    bus.cmd_key = 8'($urandom_range(0, 255));
    bus.cmd_dat = 8'($urandom_range(0, 255));
    lat = 1;
    pulses = 0;
    hold_ok = 1'b1;
    while (!bus.rsp_valid && lat < 100) begin
      if (bus.cmd_ready) hold_ok = 1'b0;
      if (bus.STB_o && (bus.KEY_o != v.key || bus.ADR_o != v.adr ||
                        bus.DAT_o != v.dat || bus.WE_o != v.we)) hold_ok = 1'b0;
      if (bus.RESET_o) pulses++;
      @(negedge sys_clk);
      lat++;
    end
    bus.cmd_valid = 1'b0;
    got_dat = bus.rsp_dat;
    got_to  = bus.rsp_timeout;
    bp_ok = 1'b1;
    for (int k = 0; k < v.hold; k++) begin
      @(negedge sys_clk);
      if (!bus.rsp_valid || bus.rsp_dat != got_dat || bus.rsp_timeout != got_to ||
          bus.cmd_ready) bp_ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge sys_clk);
    bus.rsp_ready = 1'b0;
    rel_ok = !bus.rsp_valid && bus.cmd_ready && dbg_state == IDLE;
    exp = exp_q.pop_front();
    check($sformatf("v%0d_dat", idx),    32'(got_dat), 32'(exp[7:0]));
    check($sformatf("v%0d_to", idx),     32'(got_to),  32'(exp[8]));
    check($sformatf("v%0d_lat", idx),    32'(lat),     32'(v.exp_lat));
    check($sformatf("v%0d_rstpulse", idx), 32'(pulses), v.exp_to ? 32'd1 : 32'd0);
    check($sformatf("v%0d_launch", idx), 32'(launch_ok), 32'd1);
    check($sformatf("v%0d_hold", idx),   32'(hold_ok),   32'd1);
    check($sformatf("v%0d_bp", idx),     32'(bp_ok),     32'd1);
    check($sformatf("v%0d_release", idx), 32'(rel_ok),   32'd1);
  endtask

  // ---------------- test ----------------
  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          we    adr    key    dat    hold exp    to    lat
    vecs[0] = '{1'b1, 8'h00, 8'h11, 8'hA5, 0,  8'h00, 1'b0, 4};
    vecs[1] = '{1'b1, 8'h00, 8'h22, 8'h5A, 0,  8'h01, 1'b0, 4};
    vecs[2] = '{1'b0, 8'h00, 8'h22, 8'h00, 0,  8'h5A, 1'b0, 4};
    vecs[3] = '{1'b1, 8'h03, 8'h33, 8'h77, 0,  8'h03, 1'b0, 4};
    vecs[4] = '{1'b0, 8'h03, 8'h00, 8'h00, 10, 8'h77, 1'b0, 4};
    vecs[5] = '{1'b0, 8'h00, 8'hEE, 8'h00, 0,  8'h00, 1'b1, 10};
    vecs[6] = '{1'b0, 8'h01, 8'h00, 8'h00, 0,  8'h5A, 1'b0, 4};
    vecs[7] = '{1'b1, 8'h00, 8'h44, 8'hC3, 0,  8'h02, 1'b0, 4};
    vecs[8] = '{1'b0, 8'h00, 8'h44, 8'h00, 3,  8'hC3, 1'b0, 4};
    vecs[9] = '{1'b0, 8'h01, 8'h00, 8'h00, 0,  8'h5A, 1'b0, 4};

    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_key   = '0;
    bus.cmd_dat   = '0;
    bus.rsp_ready = 1'b0;
    bus.STALL_i   = 1'b0;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_stb",     32'(bus.STB_o),       32'd0);
    check("rst_cyc",     32'(bus.CYC_o),       32'd0);
    check("rst_reset",   32'(bus.RESET_o),     32'd0);
    check("rst_we",      32'(bus.WE_o),        32'd0);
    check("rst_key",     32'(bus.KEY_o),       32'd0);
    check("rst_adr",     32'(bus.ADR_o),       32'd0);
    check("rst_dato",    32'(bus.DAT_o),       32'd0);
    check("rst_sel",     32'(bus.SEL_o),       32'hF);
    check("rst_rspv",    32'(bus.rsp_valid),   32'd0);
    check("rst_rspdat",  32'(bus.rsp_dat),     32'd0);
    check("rst_rspto",   32'(bus.rsp_timeout), 32'd0);
    check("rst_state",   32'(dbg_state),       32'(IDLE));
`ifdef KEYVALUE_INITIATOR_STATS_EN
    check("rst_ops",     32'(stat_ops),        32'd0);
    check("rst_tmo",     32'(stat_timeouts),   32'd0);
`endif
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_ready",  32'(bus.cmd_ready),   32'd1);

    // Launch gating: STALL_i or a lingering ACK_i must hold off acceptance.
    bus.STALL_i   = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    @(negedge sys_clk);
    check("stall_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge sys_clk);
    check("stall_nolaunch", 32'(bus.STB_o), 32'd0);
    bus.STALL_i = 1'b0;
    force_ack   = 1'b1;
    #1;
    check("ack_ready",   32'(bus.cmd_ready), 32'd0);
    @(negedge sys_clk);
    check("ack_nolaunch", 32'(dbg_state), 32'(IDLE));
    bus.cmd_valid = 1'b0;
    force_ack     = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 9; i++) do_cmd(i, vecs[i]);

`ifdef KEYVALUE_INITIATOR_STATS_EN
    check("stat_ops",      32'(stat_ops),      32'd8);
    check("stat_timeouts", 32'(stat_timeouts), 32'd1);
`endif

    // Reset for one cycle while a request is on the bus.
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_adr   = 8'h00;
    bus.cmd_key   = 8'h55;
    bus.cmd_dat   = 8'h66;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.cmd_valid = 1'b0;
    check("mrst_launch", 32'(bus.STB_o), 32'd1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check("mrst_stb",   32'(bus.STB_o),     32'd0);
    check("mrst_cyc",   32'(bus.CYC_o),     32'd0);
    check("mrst_rspv",  32'(bus.rsp_valid), 32'd0);
    check("mrst_state", 32'(dbg_state),     32'(IDLE));
`ifdef KEYVALUE_INITIATOR_STATS_EN
    check("mrst_ops",   32'(stat_ops),      32'd0);
    check("mrst_tmo",   32'(stat_timeouts), 32'd0);
`endif
    repeat (3) @(negedge sys_clk);
    check("mrst_noresp", 32'(bus.rsp_valid), 32'd0);

    do_cmd(9, vecs[9]);
`ifdef KEYVALUE_INITIATOR_STATS_EN
    check("post_ops", 32'(stat_ops), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyvalue_initiator.md
Name: keyvalue_initiator

Overview:
- Bus initiator for the keyvalue slave: turns a valid/ready command stream into single-beat bus cycles (insert, write-slot, lookup), captures the slave's ACK/DAT, and returns a response stream.
- Sits between a host-side controller (CPU bridge or test sequencer) and the keyvalue store.
- Recovers from lookups that never ACK (key absent) via a timeout and a RESET_o abort pulse.

Parameters:
- DW, 8, data/key/address width.
- TIMEOUT, 64, cycles waited for ACK_i before abort; range 2..65535.
- CNT_W, 16, width of the timeout counter and of the statistics counters.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset; synchronous, active-low, sampled on sys_clk rising edge.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write (ADR 0 = insert at next free slot), 0 = read (ADR 0 = lookup by key).
- cmd_adr  in  DW  slot address.
- cmd_key  in  DW  key.
- cmd_dat  in  DW  write value.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  response consumer ready.
- rsp_dat  out  DW  read value, or slot index for writes.
- rsp_timeout  out  1  response is an abort; rsp_dat = 0.
- KEY_o, ADR_o, DAT_o  out  DW each  bus key, address, write data.
- WE_o, STB_o, CYC_o  out  1 each  bus controls.
- SEL_o  out  4  constant 4'hF.
- RESET_o  out  1  one-cycle abort pulse to the slave.
- ACK_i, STALL_i  in  1 each  slave handshake.
- DAT_i  in  DW  slave read data.

Behaviour:
- Reset (sys_rst_n = 0 at a clock edge): state IDLE; all bus outputs 0 except SEL_o; rsp_valid = 0, rsp_timeout = 0, rsp_dat = 0, timer = 0, stats = 0. Reset mid-cycle drops STB_o and CYC_o the next cycle; any pending response is discarded.
- States are IDLE, REQ, RSP and ABORT.
- IDLE:
  - cmd_ready = 1 iff ACK_i == 0 and STALL_i == 0. The slave ignores STB while its ACK is still high, so no command launches then.
  - On accept, register KEY_o/ADR_o/DAT_o/WE_o from cmd_*, set STB_o = CYC_o = 1, clear timer, go to REQ.
  - Launch latency: STB_o is high in the cycle after acceptance.
- REQ:
  - Bus outputs are held stable.
  - ACK_i = 1: capture DAT_i into rsp_dat, rsp_timeout = 0; drop STB_o/CYC_o; set rsp_valid; go to RSP.
  - Timer increments each cycle without ACK_i. When the timer reaches TIMEOUT-1 without ACK_i: drop STB_o/CYC_o, assert RESET_o for exactly one cycle, go to ABORT.
  - ACK_i has priority over the timeout when both occur in the same cycle.
  - Expected ACK latency from the slave: 2 cycles after STB_o rises.
- ABORT: RESET_o = 0; rsp_valid = 1, rsp_timeout = 1, rsp_dat = 0; go to RSP.
- RSP:
  - Hold the response until rsp_valid & rsp_ready, then clear rsp_valid and go to IDLE.
  - cmd_ready = 0 while in RSP; there is no command/response overlap.
  - A rsp_ready held high gives a minimum transaction period of 5 cycles.
- Width rules: addresses and keys pass through unmodified. The timer is CNT_W bits and never wraps because it stops at TIMEOUT-1.
- cmd_* inputs change while in REQ: ignored; the registered copy drives the bus.

Optional Feature:
- Macro KEYVALUE_INITIATOR_STATS_EN.
- Defined: adds outputs stat_ops (CNT_W) and stat_timeouts (CNT_W).
  - stat_ops increments on every ACKed transaction.
  - stat_timeouts increments on every entry to ABORT.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package keyvalue_pkg:
  - state enum kvi_state_t (IDLE, REQ, RSP, ABORT);
  - constants KV_DW = 8, KV_SLOTS = 12, KV_SEL_ALL = 4'hF, KV_INSERT_ADR = 0.
- Natural sub-module: keyvalue_timeout_ctr (clear, enable, terminal-count flag at TIMEOUT-1), reused by the future stats/monitor logic.

Test Plan:
- Insert: write cmd_adr=0, key 8'h11, dat 8'hA5 -> STB_o high 1 cycle after accept, ACK 2 cycles later; rsp_dat=8'h00 (slot 0), rsp_timeout=0.
- Lookup hit: after inserts into slots 0 and 1 (key 8'h22 -> 8'h5A at slot 1), read cmd_adr=0, key 8'h22 -> rsp_dat=8'h5A. Slot 0 is not searchable by key lookup; cover it with a direct read.
- Direct read: read cmd_adr=3 after a write of 8'h77 to adr 3 -> rsp_dat=8'h77.
- Lookup miss: read key 8'hEE absent, TIMEOUT=8 -> no ACK; RESET_o pulses 1 cycle at timer 7; rsp_timeout=1, rsp_dat=0; the next command completes normally.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_dat stable, cmd_ready=0 throughout; accepted once rsp_ready=1.
- Reset mid-REQ: sys_rst_n=0 one cycle during REQ -> STB_o/CYC_o=0 and rsp_valid=0 next cycle; with KEYVALUE_INITIATOR_STATS_EN, stat_ops=0 and stat_timeouts=0.
